// File: rtl/reg_file_pkg.sv
// reg_file_pkg: clear-sequencer state encoding and default geometry shared by the register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/reg_file_clr_seq.sv
// reg_file_clr_seq: walks a counter over every entry once per clr request, one entry per cycle.
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (clr) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                CLEAR: if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_en   = busy_q;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// reg_file_param: 1-write/2-read register file with registered write-first reads,
// optional hardwired zero entry and a one-entry-per-cycle clear sweep.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int  DATA_W   = DEF_DATA_W,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd_valid,
    input  logic              clr,
    output logic              busy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rd0_data_q, rd0_data_d;
    logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
    logic              rd_valid_q;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_live;
    logic              wr_ok;

    reg_file_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // wr_live drives the bypass; wr_ok additionally masks the hardwired zero entry
    assign wr_live = wr_en && !busy;
    assign wr_ok   = wr_live && !(ZERO_REG && wr_addr == '0);

    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
        return (ZERO_REG && a == '0) ? '0 : (wr_live && a == wr_addr) ? wr_data : mem_q[a];
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) mem_d[wr_addr] = wr_data;
        if (clr_en) mem_d[clr_addr] = '0;
        rd0_data_d = rd_en ? rd_mux(rd0_addr) : rd0_data_q;
        rd1_data_d = rd_en ? rd_mux(rd1_addr) : rd1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd0_data_q <= '0;
            rd1_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd0_data_q <= rd0_data_d;
            rd1_data_q <= rd1_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign rd0_data = rd0_data_q;
    assign rd1_data = rd1_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: drives a default instance and a 32x64 zero-register instance with shared
// stimulus and checks both every cycle against an array-based model of the register file.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [5:0]  wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
    logic [31:0] wr_data = '0;
    logic [15:0] a_rd0, a_rd1;
    logic        a_rv, a_busy;
    logic [31:0] b_rd0, b_rd1;
    logic        b_rv, b_busy;

    int n_chk = 0;
    int n_fail = 0;

    // model: index 0 = default instance, index 1 = 32-bit/64-entry/zero-register instance
    logic [31:0] mm [2][64];
    int          cl_left [2];
    int          cl_pos [2];
    logic [31:0] e_rd0 [2];
    logic [31:0] e_rd1 [2];
    logic        e_rv [2];

    always #5 clk = ~clk;

    reg_file_param u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[15:0]),
        .rd_en(rd_en), .rd0_addr(rd0_addr[3:0]), .rd1_addr(rd1_addr[3:0]),
        .rd0_data(a_rd0), .rd1_data(a_rd1), .rd_valid(a_rv), .clr(clr), .busy(a_busy)
    );

    reg_file_param #(.DATA_W(32), .DEPTH(64), .ZERO_REG(1'b1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(b_rd0), .rd1_data(b_rd1), .rd_valid(b_rv), .clr(clr), .busy(b_busy)
    );

    function automatic int dep(input int k);
        return (k != 0) ? 64 : 16;
    endfunction

    function automatic logic [31:0] msk(input int k);
        return (k != 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) mm[k][i] = '0;
            cl_left[k] = 0;
            cl_pos[k]  = 0;
            e_rd0[k]   = '0;
            e_rd1[k]   = '0;
            e_rv[k]    = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          wa = int'(wr_addr) % dep(k);
            int          r0 = int'(rd0_addr) % dep(k);
            int          r1 = int'(rd1_addr) % dep(k);
            logic [31:0] wd = wr_data & msk(k);
            bit          zr = (k == 1);
            bit          bsy = cl_left[k] > 0;
            bit          live = wr_en && !bsy;
            if (rd_en) begin
                e_rd0[k] = (zr && r0 == 0) ? 32'h0 : (live && r0 == wa) ? wd : mm[k][r0];
                e_rd1[k] = (zr && r1 == 0) ? 32'h0 : (live && r1 == wa) ? wd : mm[k][r1];
            end
            e_rv[k] = rd_en;
            if (live && !(zr && wa == 0)) mm[k][wa] = wd;
            if (bsy) begin
                mm[k][cl_pos[k]] = '0;
                cl_pos[k]++;
                cl_left[k]--;
            end else if (clr) begin
                cl_left[k] = dep(k);
                cl_pos[k]  = 0;
            end
        end
    endtask

    task automatic compare();
        chk("a_busy", 64'(a_busy), 64'(cl_left[0] > 0));
        chk("a_rd_valid", 64'(a_rv), 64'(e_rv[0]));
        chk("a_rd0", 64'(a_rd0), 64'(e_rd0[0]));
        chk("a_rd1", 64'(a_rd1), 64'(e_rd1[0]));
        chk("b_busy", 64'(b_busy), 64'(cl_left[1] > 0));
        chk("b_rd_valid", 64'(b_rv), 64'(e_rv[1]));
        chk("b_rd0", 64'(b_rd0), 64'(e_rd0[1]));
        chk("b_rd1", 64'(b_rd1), 64'(e_rd1[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set(input logic we, input int wa, input logic [31:0] wd,
                       input logic re, input int a0, input int a1, input logic c);
        wr_en = we; wr_addr = 6'(wa); wr_data = wd;
        rd_en = re; rd0_addr = 6'(a0); rd1_addr = 6'(a1); clr = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_rv", 64'(a_rv), 64'd0);
        chk("rst_a_rd0", 64'(a_rd0), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        chk("rst_b_rd1", 64'(b_rd1), 64'd0);
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        set(0, 0, 0, 0, 0, 0, 0);
        while ((a_busy || b_busy) && t < 100) begin
            cycle();
            t++;
        end
        chk(nm, 64'(a_busy || b_busy), 64'd0);
    endtask

    initial begin
        int n0, n1;
        @(negedge clk);
        do_reset();
        // single write then dual read of the same entry
        set(1, 5, 32'h1234, 0, 0, 0, 0); cycle();
        set(0, 0, 0, 1, 5, 5, 0); cycle();
        chk("rd0_after_wr", 64'(a_rd0), 64'h1234);
        chk("rd1_after_wr", 64'(a_rd1), 64'h1234);
        chk("rv_pulse", 64'(a_rv), 64'd1);
        set(1, 4, 32'h0011, 0, 0, 0, 0); cycle();
        chk("rv_drop", 64'(a_rv), 64'd0);
        chk("rd0_hold", 64'(a_rd0), 64'h1234);
        // write-first bypass on port 0 only
        set(1, 3, 32'hBEEF, 1, 3, 4, 0); cycle();
        chk("bypass_rd0", 64'(a_rd0), 64'hBEEF);
        chk("bypass_rd1", 64'(a_rd1), 64'h0011);
        // zero register vs ordinary entry 0
        set(1, 0, 32'hFFFF, 1, 0, 0, 0); cycle();
        chk("zero_bypass", 64'(b_rd0), 64'h0);
        chk("nozero_bypass", 64'(a_rd0), 64'hFFFF);
        set(0, 0, 0, 1, 0, 5, 0); cycle();
        chk("zero_read", 64'(b_rd0), 64'h0);
        chk("b_rd1_addr5", 64'(b_rd1), 64'h1234);
        // fill, then sweep with a read, a blocked write and an ignored clr while busy
        for (int i = 0; i < 16; i++) begin
            set(1, i, 32'hA5A5, 0, 0, 0, 0); cycle();
        end
        set(0, 0, 0, 0, 0, 0, 1); cycle();
        n0 = 0; n1 = 0;
        for (int i = 0; i < 100; i++) begin
            n0 += int'(a_busy);
            n1 += int'(b_busy);
            set(i == 2, 15, 32'h1111, i == 1, 15, 7, i == 2);
            cycle();
            if (i == 1) chk("clr_read_old", 64'(a_rd0), 64'hA5A5);
        end
        chk("busy_len_a", 64'(n0), 64'd16);
        chk("busy_len_b", 64'(n1), 64'd64);
        for (int i = 0; i < 16; i++) begin
            set(0, 0, 0, 1, i, 15 - i, 0); cycle();
        end
        chk("cleared_rd0", 64'(a_rd0), 64'h0);
        // write and clr on the same edge: the sweep must wipe the write
        set(1, 9, 32'h7777, 0, 0, 0, 1); cycle();
        wait_idle("sweep_timeout_1");
        set(0, 0, 0, 1, 9, 9, 0); cycle();
        chk("wr_clr_same", 64'(a_rd0), 64'h0);
        // reset part-way through a sweep
        set(1, 12, 32'h5555, 0, 0, 0, 0); cycle();
        set(0, 0, 0, 0, 0, 0, 1); cycle();
        for (int i = 0; i < 6; i++) begin
            set(0, 0, 0, 1, 12, 12, 0); cycle();
        end
        chk("pre_rst_rd0", 64'(a_rd0), 64'h5555);
        do_reset();
        for (int i = 0; i < 64; i++) begin
            set(0, 0, 0, 1, i, 63 - i, 0); cycle();
        end
        chk("post_rst_rd0", 64'(b_rd0), 64'h0);
        // wide instance, top entry
        set(1, 63, 32'hDEADBEEF, 0, 0, 0, 0); cycle();
        set(0, 0, 0, 1, 63, 62, 0); cycle();
        chk("wide_top", 64'(b_rd0), 64'hDEADBEEF);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] wa = 6'($urandom);
            set($urandom_range(1), int'(wa), $urandom, $urandom_range(1),
                ($urandom_range(3) == 0) ? int'(wa) : int'(6'($urandom)),
                ($urandom_range(3) == 0) ? int'(wa) : int'(6'($urandom)),
                $urandom_range(39) == 0);
            if ($urandom_range(299) == 0) do_reset();
            else cycle();
        end
        wait_idle("sweep_timeout_2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, 2..256).
REQ-003 SHALL have parameter ZERO_REG, default 0; when 1, entry 0 always reads as zero and ignores writes.
REQ-004 SHALL derive local constant ADDR_W = log2(DEPTH).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, 1, read strobe shared by both read ports.
REQ-011 SHALL have ports rd0_addr and rd1_addr, input, ADDR_W each, read addresses.
REQ-012 SHALL have ports rd0_data and rd1_data, output, DATA_W each, registered read data.
REQ-013 SHALL have port rd_valid, output, 1, high for the cycle rd0_data/rd1_data carry data from a read issued the previous cycle.
REQ-014 SHALL have port clr, input, 1, request to sweep-clear all entries.
REQ-015 SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-016 Write: when wr_en=1 and busy=0 at a rising edge, entry wr_addr SHALL take wr_data; wr_en SHALL be ignored while busy=1.
REQ-017 Read: when rd_en=1 at a rising edge, rdN_data SHALL load entry rdN_addr; latency one cycle; rd_valid SHALL equal rd_en delayed one cycle.
REQ-018 When rd_en=0, rd0_data and rd1_data SHALL hold their previous values.
REQ-019 Bypass: if rd_en=1, wr_en=1, busy=0 and rdN_addr==wr_addr in the same cycle, rdN_data SHALL load wr_data (write-first), independently per port.
REQ-020 ZERO_REG=1: reads of address 0 SHALL return zero, including under bypass; writes to address 0 SHALL have no effect.
REQ-021 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR when clr=1; CLEAR->IDLE after the entry at index DEPTH-1 is cleared.
REQ-022 In CLEAR, a counter starting at 0 SHALL zero one entry per cycle, incrementing by 1; the sweep SHALL take exactly DEPTH cycles.
REQ-023 busy SHALL be high from the cycle after clr is sampled through the last clear cycle inclusive (DEPTH cycles), then low.
REQ-024 clr asserted while busy=1 SHALL be ignored (no restart); clr asserted in the cycle busy falls SHALL start a new sweep.
REQ-025 Reads during CLEAR SHALL be serviced normally and return current contents (zero for already-cleared entries, old data otherwise); no bypass from the clear counter.
REQ-026 A write and clr sampled on the same edge in IDLE: the write SHALL complete, then the sweep SHALL clear it.
REQ-027 Counter SHALL be ADDR_W bits wide and SHALL not wrap past DEPTH-1 into a second sweep.

Reset
REQ-028 While rst=1, all entries, rd0_data, rd1_data, rd_valid, busy and the clear counter SHALL be zero and the FSM SHALL be IDLE, asynchronously.
REQ-029 rst asserted mid-sweep SHALL abort the sweep; after release the block SHALL be IDLE with all entries zero.
REQ-030 First rising edge after rst deasserts SHALL be a normal functional edge.

Structure
REQ-031 FSM state encoding (IDLE, CLEAR) SHALL live in shared package reg_file_pkg, with default DATA_W/DEPTH constants.
REQ-032 Storage array plus write/bypass logic SHALL be one module; the clear sequencer SHALL be sub-module reg_file_clr_seq (FSM, counter, busy, clear address/strobe).
REQ-033 No other sub-modules.

Verification
REQ-034 Defaults: write 0x1234 to addr 5, next cycle read rd0=5, rd1=5 -> both 0x1234 one cycle later, rd_valid=1 for one cycle.
REQ-035 Bypass: same cycle wr_addr=3 wr_data=0xBEEF, rd0_addr=3, rd1_addr=4 (holds 0x0011) -> rd0_data=0xBEEF, rd1_data=0x0011.
REQ-036 ZERO_REG=1: write 0xFFFF to addr 0, read addr 0 (also same-cycle bypass) -> 0x0000.
REQ-037 Fill all 16 entries with 0xA5A5, pulse clr -> busy high exactly 16 cycles; reading addr 15 during cycle 2 returns 0xA5A5; after busy falls all reads return 0; write during busy has no effect; clr during busy does not extend it.
REQ-038 Assert rst at clear cycle 7 -> busy=0, rd_valid=0, outputs 0 immediately; after release all entries read 0.
REQ-039 DATA_W=32, DEPTH=64: write 0xDEADBEEF to addr 63, read -> 0xDEADBEEF; clr sweep lasts 64 cycles.
